wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port among up to 7 result sources (ALU, load, PC+4, immediate, CSR, multiplier, divider).
- Drives the 3-bit select of the 32-bit 7:1 writeback data mux.
- Issues a per-source ack and produces the registered write-enable and destination register for the register file.
- Uses fixed priority (lowest index wins), with per-source aging counters so no source starves.

Parameters:
- NUM_SRC, 7, number of requesters. Fixed by the 3-bit mux select; select codes 0-6 only.
- MAX_WAIT, 8, number of lost arbitration cycles after which a source becomes urgent. Legal range 1-15.
- CNT_W, 4, aging counter width. Must hold MAX_WAIT.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- req  in  7  per-source write request; bit i belongs to source i.
- rd_in  in  35  packed destination registers; bits [5i+4:5i] belong to source i.
- stall  in  1  pipeline stall; blocks all grants while high.
- ack  out  7  one-hot grant, combinational, same cycle as the winning req.
- mux_sel  out  3  select for the writeback data mux.
- wb_en  out  1  register-file write enable, registered.
- wb_rd  out  5  register-file destination, registered.
- urgent  out  7  per-source flag; bit i high when cnt[i] == MAX_WAIT. Debug/visibility only.

Behaviour:
- Reset (synchronous, RESET high at the rising edge of CLK):
  - All aging counters clear to 0.
  - wb_en <= 0, wb_rd <= 0.
  - Select-hold register sel_q <= 0.
- While RESET is high: ack = 0 and mux_sel = sel_q.
- Arbitration (combinational, each cycle with RESET = 0, stall = 0, req != 0):
  - If any requesting source has cnt == MAX_WAIT, the lowest-index such source wins.
  - Otherwise the lowest-index requesting source wins.
  - Exactly one ack bit is high; mux_sel = winner index.
- No grant (stall = 1 or req == 0):
  - ack = 0 and mux_sel = sel_q. The select holds, so the mux output is stable.
- Registered outputs, one cycle after a grant:
  - wb_en = 1 unless the winner's rd == 0, in which case wb_en = 0 (x0 write suppressed; the ack is still given).
  - wb_rd = winner's rd.
  - sel_q <= winner index.
- After a no-grant cycle: wb_en = 0 and wb_rd holds its previous value.
- Latency: ack and mux_sel in cycle N; wb_en and wb_rd in cycle N+1. This aligns with the downstream writeback data register capturing the mux output at the end of cycle N.
- Handshake:
  - A source holds req and its rd field stable until it sees ack.
  - The transfer completes at the edge where ack = 1.
  - A source may keep req high to present a new result in the following cycle; that request is a new request.
  - Dropping req without ack (flush) is legal; that source's counter clears.
- Aging counters, per source i, updated each edge:
  - RESET: 0.
  - Else if ack[i] or !req[i]: 0.
  - Else (req[i] && !ack[i]): min(cnt + 1, MAX_WAIT).
  - Counters increment during stall too, saturating at MAX_WAIT.
- Simultaneous urgents resolve by lowest index. Fairness is bounded: an urgent source is served within 7 grant cycles.
- Reset mid-operation: pending requests are not acked while RESET is high. Counters and wb_en clear on the next edge; the in-flight wb_en from the previous cycle is dropped.
- A req bit that is X/Z is a bench error and is not handled.

Test Plan:
- Reset: RESET = 1 for 2 cycles with req = 7'h7F -> ack = 0, mux_sel = 0, wb_en = 0; first cycle after release -> ack = 7'h01, mux_sel = 0, next cycle wb_en = 1, wb_rd = rd0.
- Priority: req = 7'b0010110, rd1 = 5, rd2 = 9, rd4 = 12, each source dropping its req after ack -> acks in order 1, 2, 4; mux_sel 1, 2, 4; wb_rd 5, 9, 12 each one cycle later.
- Aging: req0 held high continuously, req5 high from cycle 0, MAX_WAIT = 8 -> src0 wins cycles 0-7; cycle 8 urgent[5] = 1, ack = 7'h20, mux_sel = 5; cnt5 returns to 0; cycle 9 src0 wins again.
- Stall: req2 = 1 with stall = 1 for 3 cycles after a prior grant to src4 -> ack = 0, mux_sel stays 4, wb_en = 0, cnt2 = 3; stall drops -> ack = 7'h04, mux_sel = 2.
- x0 suppression: req3 = 1 with rd3 = 0 -> ack = 7'h08, mux_sel = 3; next cycle wb_en = 0, wb_rd = 0.
- Mid-operation reset: cnt5 = 6 and a grant to src1 in cycle N, RESET = 1 in cycle N+1 -> wb_en = 0 from N+2, all counters 0, ack = 0 during reset.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port handshake bundle: per-source request/destination in, grant and register-file controls out.
// Latency: none. This is wires only.
// Backpressure: stall travels alongside req and blocks every grant while it is high.
//
// Signals:
//   req     per-source write request (bit i = source i)
//   rd_in   packed destination registers, bits [5i+4:5i] = source i
//   stall   pipeline stall, no grant while high
//   ack     one-hot grant, combinational
//   mux_sel writeback data mux select
//   wb_en   registered register-file write enable
//   wb_rd   registered register-file destination
//   urgent  per-source aging-saturated flag, for visibility
interface wb_port_arbiter_if #(
    parameter int NUM_SRC = 7,
    parameter int RD_W    = 5,
    parameter int SEL_W   = 3
);
    logic [NUM_SRC-1:0]      req;
    logic [NUM_SRC*RD_W-1:0] rd_in;
    logic                    stall;
    logic [NUM_SRC-1:0]      ack;
    logic [SEL_W-1:0]        mux_sel;
    logic                    wb_en;
    logic [RD_W-1:0]         wb_rd;
    logic [NUM_SRC-1:0]      urgent;

    // Result sources and pipeline control drive the requests.
    modport master (
        output req, rd_in, stall,
        input  ack, mux_sel, wb_en, wb_rd, urgent
    );

    // The arbiter consumes the requests and drives the grants.
    modport slave (
        input  req, rd_in, stall,
        output ack, mux_sel, wb_en, wb_rd, urgent
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port among 7 result sources, using fixed priority plus aging.
// Latency: ack/mux_sel are combinational in cycle N; wb_en/wb_rd are registered and appear in cycle N+1.
// Backpressure: stall or RESET suppresses all grants; waiting sources keep aging and saturate at MAX_WAIT.
//
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset
//   bus    wb_port_arbiter_if slave: req/rd_in/stall in; ack/mux_sel/wb_en/wb_rd/urgent out
module wb_port_arbiter #(
    parameter int NUM_SRC  = 7,
    parameter int MAX_WAIT = 8,
    parameter int CNT_W    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    wb_port_arbiter_if.slave bus
);
    localparam int SEL_W = 3;
    localparam int RD_W  = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]   cnt [NUM_SRC];
    logic [NUM_SRC-1:0] urgent_vec;
    logic [NUM_SRC-1:0] urgent_req;
    logic [NUM_SRC-1:0] pick;
    logic [NUM_SRC-1:0] ack_vec;
    logic               grant_vld;
    logic [SEL_W-1:0]   win_idx;
    logic [RD_W-1:0]    win_rd;
    logic [SEL_W-1:0]   sel_q;
    logic               wb_en_q;
    logic [RD_W-1:0]    wb_rd_q;

    always_comb begin
        urgent_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            urgent_vec[i] = (cnt[i] == CNT_MAX);
        end
    end

    // Urgent requesters form a higher priority tier. Within a tier the lowest index wins.
    assign urgent_req = bus.req & urgent_vec;
    assign pick       = (|urgent_req) ? urgent_req : bus.req;
    assign grant_vld  = !RESET && !bus.stall && (|bus.req);

    // Scan from the top down so that the last hit is the lowest set index.
    always_comb begin
        win_idx = '0;
        win_rd  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = SEL_W'(i);
                win_rd  = bus.rd_in[i*RD_W +: RD_W];
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        if (grant_vld) begin
            ack_vec[win_idx] = 1'b1;
        end
    end

    assign bus.ack     = ack_vec;
    // With no grant the select holds its last winner, so the data mux output stays stable.
    assign bus.mux_sel = grant_vld ? win_idx : sel_q;
    assign bus.urgent  = urgent_vec;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_rd   = wb_rd_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wb_en_q <= 1'b0;
            wb_rd_q <= '0;
            sel_q   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // A write to x0 is still acked, but it never reaches the register file.
            wb_en_q <= grant_vld && (win_rd != '0);
            if (grant_vld) begin
                wb_rd_q <= win_rd;
                sel_q   <= win_idx;
            end
            // Age counts consecutive lost cycles. A served or withdrawn request starts over.
            for (int i = 0; i < NUM_SRC; i++) begin
                if (ack_vec[i] || !bus.req[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
    localparam int MAX_WAIT = 8;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    wb_port_arbiter_if #(.NUM_SRC(7)) bus ();

    wb_port_arbiter #(.NUM_SRC(7), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: wait age per source, plus the registered outputs and select hold.
    int       age [7];
    bit       m_wb_en;
    bit [4:0] m_wb_rd;
    int       m_sel;

    logic [6:0] obs_ack, obs_urg, exp_ack;
    logic [2:0] obs_sel;
    logic       obs_wb_en;
    logic [4:0] obs_wb_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (age[i]) age[i] = 0;
        m_wb_en = 0;
        m_wb_rd = 0;
        m_sel   = 0;
    endtask

    // One clock cycle: drive the inputs, compare at mid-cycle against the model, advance the model, then cross the edge.
    task automatic cycle(input logic [6:0] r, input logic [34:0] rd, input bit st, input bit rs, input string tag);
        int win;
        logic [6:0] e_urg;
        logic [2:0] e_sel;
        logic [4:0] e_rd;
        bus.req   = r;
        bus.rd_in = rd;
        bus.stall = st;
        RESET     = rs;
        #4;
        win   = -1;
        exp_ack = '0;
        e_sel = 3'(m_sel);
        e_rd  = '0;
        for (int i = 0; i < 7; i++) e_urg[i] = (age[i] == MAX_WAIT);
        if (!rs && !st && r != 0) begin
            for (int i = 0; i < 7; i++) if (r[i] && age[i] == MAX_WAIT && win < 0) win = i;
            for (int i = 0; i < 7; i++) if (r[i] && win < 0) win = i;
            exp_ack[win] = 1'b1;
            e_sel = 3'(win);
            e_rd  = rd[5*win +: 5];
        end
        obs_ack   = bus.ack;
        obs_sel   = bus.mux_sel;
        obs_urg   = bus.urgent;
        obs_wb_en = bus.wb_en;
        obs_wb_rd = bus.wb_rd;
        check({tag, "_ack"},    32'(obs_ack),   32'(exp_ack));
        check({tag, "_sel"},    32'(obs_sel),   32'(e_sel));
        check({tag, "_urgent"}, 32'(obs_urg),   32'(e_urg));
        check({tag, "_wb_en"},  32'(obs_wb_en), 32'(m_wb_en));
        check({tag, "_wb_rd"},  32'(obs_wb_rd), 32'(m_wb_rd));
        if (rs) begin
            model_reset();
        end else begin
            m_wb_en = (win >= 0) && (e_rd != 0);
            if (win >= 0) begin
                m_wb_rd = e_rd;
                m_sel   = win;
            end
            for (int i = 0; i < 7; i++) begin
                if (exp_ack[i] || !r[i]) age[i] = 0;
                else if (age[i] < MAX_WAIT) age[i] = age[i] + 1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [34:0] rdv;
        bit       pend [7];
        bit [4:0] prd  [7];
        logic [6:0]  r;
        logic [34:0] rv;
        bit st, rs;

        // rd per source: 3, 5, 9, 0, 12, 17, 30
        rdv = {5'd30, 5'd17, 5'd12, 5'd0, 5'd9, 5'd5, 5'd3};
        RESET     = 1'b1;
        bus.req   = 7'h7F;
        bus.rd_in = rdv;
        bus.stall = 1'b0;
        @(posedge CLK);
        #1;
        model_reset();

        // Reset with every source requesting
        cycle(7'h7F, rdv, 0, 1, "rst0");
        cycle(7'h7F, rdv, 0, 1, "rst1");
        check("rst_ack", 32'(obs_ack), 32'h0);
        check("rst_sel", 32'(obs_sel), 32'h0);
        check("rst_wb_en", 32'(obs_wb_en), 32'h0);
        cycle(7'h7F, rdv, 0, 0, "rel");
        check("rel_ack", 32'(obs_ack), 32'h01);
        cycle(7'h00, rdv, 0, 0, "rel_wb");
        check("rel_wb_en", 32'(obs_wb_en), 32'h1);
        check("rel_wb_rd", 32'(obs_wb_rd), 32'd3);

        // Fixed priority: 1, 2, 4
        cycle(7'b0010110, rdv, 0, 0, "pri_a");
        check("pri_a_ack", 32'(obs_ack), 32'h02);
        cycle(7'b0010100, rdv, 0, 0, "pri_b");
        check("pri_b_ack", 32'(obs_ack), 32'h04);
        check("pri_b_wb_rd", 32'(obs_wb_rd), 32'd5);
        cycle(7'b0010000, rdv, 0, 0, "pri_c");
        check("pri_c_sel", 32'(obs_sel), 32'd4);
        check("pri_c_wb_rd", 32'(obs_wb_rd), 32'd9);
        cycle(7'b0000000, rdv, 0, 0, "pri_d");
        check("pri_d_wb_rd", 32'(obs_wb_rd), 32'd12);

        // Stall holds the select from the src4 grant
        for (int k = 0; k < 3; k++) begin
            cycle(7'h04, rdv, 1, 0, "stall");
            check("stall_ack", 32'(obs_ack), 32'h0);
            check("stall_sel", 32'(obs_sel), 32'd4);
        end
        cycle(7'h04, rdv, 0, 0, "unstall");
        check("unstall_ack", 32'(obs_ack), 32'h04);
        check("unstall_sel", 32'(obs_sel), 32'd2);
        cycle(7'h00, rdv, 0, 0, "idle0");

        // Aging: src5 starves behind src0 until it becomes urgent
        for (int k = 0; k < 10; k++) begin
            cycle(7'h21, rdv, 0, 0, "age");
            if (k == 8) begin
                check("age_urgent8", 32'(obs_urg), 32'h20);
                check("age_ack8", 32'(obs_ack), 32'h20);
                check("age_sel8", 32'(obs_sel), 32'd5);
            end else begin
                check("age_ack", 32'(obs_ack), 32'h01);
            end
        end
        cycle(7'h00, rdv, 0, 0, "idle1");

        // Write to x0 is acked but not enabled
        cycle(7'h08, rdv, 0, 0, "x0");
        check("x0_ack", 32'(obs_ack), 32'h08);
        check("x0_sel", 32'(obs_sel), 32'd3);
        cycle(7'h00, rdv, 0, 0, "x0_wb");
        check("x0_wb_en", 32'(obs_wb_en), 32'h0);
        check("x0_wb_rd", 32'(obs_wb_rd), 32'd0);

        // Reset mid-operation: src5 aged to 6 while src1 is granted
        for (int k = 0; k < 7; k++) cycle(7'h22, rdv, 0, 0, "mid");
        cycle(7'h22, rdv, 0, 1, "mid_rst");
        check("mid_rst_ack", 32'(obs_ack), 32'h0);
        cycle(7'h22, rdv, 0, 0, "mid_post");
        check("mid_post_wb_en", 32'(obs_wb_en), 32'h0);
        check("mid_post_urgent", 32'(obs_urg), 32'h0);
        for (int k = 0; k < 9; k++) cycle(7'h22, rdv, 0, 0, "mid_age");
        cycle(7'h00, rdv, 0, 0, "idle2");

        // Random traffic: sources hold req/rd until acked; occasional flushes, stalls, and resets
        foreach (pend[i]) begin
            pend[i] = 0;
            prd[i]  = 0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 7; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 30) begin
                    pend[i] = 1;
                    prd[i]  = 5'($urandom_range(0, 31));
                end else if (pend[i] && $urandom_range(0, 99) < 3) begin
                    pend[i] = 0;
                end
            end
            for (int i = 0; i < 7; i++) begin
                r[i]        = pend[i];
                rv[5*i +: 5] = prd[i];
            end
            st = ($urandom_range(0, 99) < 15);
            rs = ($urandom_range(0, 199) == 0);
            cycle(r, rv, st, rs, "rnd");
            for (int i = 0; i < 7; i++) if (exp_ack[i]) pend[i] = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
